bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq_pkg.sv | 17 +
 rtl/bin_to_bcd_seq_bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display definitions for the 6-digit 7-segment board and the
// sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int unsigned BCD_NIBBLE_W = 4;
    localparam int unsigned BOARD_DIGITS = 6;

    // Nibble used to build the saturated all-nines display pattern.
    localparam logic [BCD_NIBBLE_W-1:0] BCD_NINE = 4'h9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] digit,
    output logic [BCD_NIBBLE_W-1:0] adj_c
);

    always_comb begin
        adj_c = digit;
        if (digit >= BCD_NIBBLE_W'(5)) begin
            adj_c = digit + BCD_NIBBLE_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with a start/busy/done
// handshake; one shift per clock, result held until the next conversion.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = BOARD_DIGITS
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [BIN_W-1:0]               bin_in,
    output logic                           busy,
    output logic                           done,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out,
    output logic                           ovf
);

    localparam int unsigned BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [BCD_W-1:0] BCD_SAT = {DIGITS{BCD_NINE}};

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_shift;
    logic               sticky_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .adj_c (adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
    always_comb begin
        scratch_shift = {adj[BCD_W-2:0], shreg[BIN_W-1]};
        sticky_next   = sticky | adj[BCD_W-1];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_shift;
                    shreg   <= shreg << 1;
                    sticky  <= sticky_next;
                    cnt     <= cnt - CNT_W'(1);
                    // Final shift: publish the result on the edge that raises done.
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        bcd_out <= sticky_next ? BCD_SAT : scratch_shift;
                        ovf     <= sticky_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
